// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared writeback-stage types and load encodings
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - sub-word load lane select, sign/zero extension, alignment flag
module load_extract
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] i_mem_data,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data,
    output logic            o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_mem_data[7:0];
        case (i_off)
            2'd1:    w_byte = i_mem_data[15:8];
            2'd2:    w_byte = i_mem_data[23:16];
            2'd3:    w_byte = i_mem_data[31:24];
            default: w_byte = i_mem_data[7:0];
        endcase
        w_half = i_off[1] ? i_mem_data[31:16] : i_mem_data[15:0];
    end

    // Unknown funct3 encodings behave as LW, including the alignment rule.
    always_comb begin
        o_data     = i_mem_data;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH: begin
                o_data     = {{(XLEN-16){w_half[15]}}, w_half};
                o_misalign = i_off[0];
            end
            F3_LHU: begin
                o_data     = {{(XLEN-16){1'b0}}, w_half};
                o_misalign = i_off[0];
            end
            default: begin
                o_data     = i_mem_data;
                o_misalign = (i_off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB writeback select, integer register file with WB->ID bypass, instret
// Optional write trace under WB_REGFILE_TRACE_EN.
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid_in,
    input  logic [XLEN-1:0]  mem_data_in,
    input  logic [XLEN-1:0]  alu_result_in,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [4:0]       rd_in,
    input  logic [1:0]       wb_sel_in,
    input  logic             mem_to_reg_in,
    input  logic             reg_write_in,
    input  logic [2:0]       funct3_in,
    input  logic [4:0]       rs1_addr_in,
    input  logic [4:0]       rs2_addr_in,
    output logic [XLEN-1:0]  rs1_data_out,
    output logic [XLEN-1:0]  rs2_data_out,
    output logic [XLEN-1:0]  wb_data_out,
    output logic             misalign_out,
    output logic [CNT_W-1:0] instret_out
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [CNT_W-1:0] r_instret;
    logic             r_misalign;

    logic [XLEN-1:0]  w_load_data;
    logic             w_lane_misalign;
    logic             w_mem_sel;
    logic             w_misalign;
    logic             w_we;

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .i_mem_data (mem_data_in),
        .i_off      (alu_result_in[1:0]),
        .i_funct3   (funct3_in),
        .o_data     (w_load_data),
        .o_misalign (w_lane_misalign)
    );

    assign w_mem_sel  = mem_to_reg_in || (wb_sel_in == WB_MEM);
    assign w_misalign = wb_valid_in && w_mem_sel && w_lane_misalign;
    assign w_we       = wb_valid_in && reg_write_in && (rd_in != 5'd0) && !w_misalign;

    always_comb begin
        wb_data_out = alu_result_in;
        if (w_mem_sel)
            wb_data_out = w_load_data;
        else if (wb_sel_in == WB_PC4)
            wb_data_out = pc_in + XLEN'(4);
    end

    // Write-through: a read of the register being written this cycle sees the new value.
    always_comb begin
        rs1_data_out = r_regs[rs1_addr_in];
        rs2_data_out = r_regs[rs2_addr_in];
        if (rs1_addr_in == 5'd0)
            rs1_data_out = '0;
        else if (w_we && rs1_addr_in == rd_in)
            rs1_data_out = wb_data_out;
        if (rs2_addr_in == 5'd0)
            rs2_data_out = '0;
        else if (w_we && rs2_addr_in == rd_in)
            rs2_data_out = wb_data_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_instret  <= '0;
            r_misalign <= 1'b0;
        end else begin
            if (w_we)
                r_regs[rd_in] <= wb_data_out;
            if (wb_valid_in)
                r_instret <= r_instret + CNT_W'(1);
            r_misalign <= w_misalign;
        end
    end

    assign instret_out  = r_instret;
    assign misalign_out = r_misalign;

`ifdef WB_REGFILE_TRACE_EN
    logic [63:0] r_trace_cycle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trace_cycle <= '0;
        end else begin
            r_trace_cycle <= r_trace_cycle + 64'd1;
            if (w_we)
                $display("wb trace cyc=%0d pc=%h rd=x%0d val=%h",
                         r_trace_cycle, pc_in, rd_in, wb_data_out);
        end
    end
`else
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized and directed bench for wb_regfile against a behavioural model
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid_in;
    logic [31:0] mem_data_in;
    logic [31:0] alu_result_in;
    logic [31:0] pc_in;
    logic [4:0]  rd_in;
    logic [1:0]  wb_sel_in;
    logic        mem_to_reg_in;
    logic        reg_write_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rs1_addr_in;
    logic [4:0]  rs2_addr_in;
    logic [31:0] rs1_data_out;
    logic [31:0] rs2_data_out;
    logic [31:0] wb_data_out;
    logic        misalign_out;
    logic [63:0] instret_out;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .wb_valid_in   (wb_valid_in),
        .mem_data_in   (mem_data_in),
        .alu_result_in (alu_result_in),
        .pc_in         (pc_in),
        .rd_in         (rd_in),
        .wb_sel_in     (wb_sel_in),
        .mem_to_reg_in (mem_to_reg_in),
        .reg_write_in  (reg_write_in),
        .funct3_in     (funct3_in),
        .rs1_addr_in   (rs1_addr_in),
        .rs2_addr_in   (rs2_addr_in),
        .rs1_data_out  (rs1_data_out),
        .rs2_data_out  (rs2_data_out),
        .wb_data_out   (wb_data_out),
        .misalign_out  (misalign_out),
        .instret_out   (instret_out)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_regs [32];
    logic [63:0] m_instret;
    logic        m_mis;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] mem, input int off, input int f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (mem >> (8 * off)) & 32'hFF;
        h = (mem >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            0:       return (b >= 128) ? b - 32'd256 : b;
            4:       return b;
            1:       return (h >= 32768) ? h - 32'd65536 : h;
            5:       return h;
            default: return mem;
        endcase
    endfunction

    function automatic bit m_bad_align(input int off, input int f3);
        if (f3 == 0 || f3 == 4) return 1'b0;
        if (f3 == 1 || f3 == 5) return (off % 2) != 0;
        return off != 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_instret = 64'h0;
        m_mis     = 1'b0;
    endtask

    // One writeback cycle: drive at negedge, check combinational and registered outputs, advance.
    task automatic step(input bit v, input bit rw, input logic [1:0] sel, input bit m2r,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit use_exp, input logic [31:0] exp_wb);
        bit          memsel;
        bit          mis;
        bit          we;
        logic [31:0] wb;
        logic [31:0] e1;
        logic [31:0] e2;
        wb_valid_in = v; reg_write_in = rw; wb_sel_in = sel; mem_to_reg_in = m2r;
        funct3_in = f3; rd_in = rd; alu_result_in = alu; mem_data_in = mem; pc_in = pc;
        rs1_addr_in = rs1; rs2_addr_in = rs2;
        #1;
        memsel = m2r || (sel == 2'd1);
        if (memsel)           wb = m_load(mem, int'(alu % 4), int'(f3));
        else if (sel == 2'd2) wb = pc + 32'd4;
        else                  wb = alu;
        mis = v && memsel && m_bad_align(int'(alu % 4), int'(f3));
        we  = v && rw && (rd != 0) && !mis;
        e1  = (rs1 == 0) ? 32'h0 : (we && rs1 == rd) ? wb : m_regs[rs1];
        e2  = (rs2 == 0) ? 32'h0 : (we && rs2 == rd) ? wb : m_regs[rs2];
        chk("wb_data", wb_data_out, wb);
        chk("rs1", rs1_data_out, e1);
        chk("rs2", rs2_data_out, e2);
        chk("misalign", misalign_out, m_mis);
        chk("instret", instret_out, m_instret);
        if (use_exp) chk("directed_wb", wb_data_out, exp_wb);
        @(posedge clk);
        if (we) m_regs[rd] = wb;
        if (v) m_instret = m_instret + 64'd1;
        m_mis = mis;
        @(negedge clk);
    endtask

    task automatic bubble(input logic [4:0] rs1);
        step(1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, rs1, 5'd0, 1'b0, 32'h0);
    endtask

    localparam logic [31:0] LD_WORD = 32'h80FF7F01;

    initial begin
        reset = 1'b1;
        wb_valid_in = 0; reg_write_in = 0; wb_sel_in = 0; mem_to_reg_in = 0; funct3_in = 0;
        rd_in = 0; alu_result_in = 0; mem_data_in = 0; pc_in = 0; rs1_addr_in = 0; rs2_addr_in = 0;
        model_clear();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            rs1_addr_in = 5'(i);
            #1 chk("reset_read", rs1_data_out, 32'h0);
        end
        chk("reset_instret", instret_out, 64'h0);
        chk("reset_misalign", misalign_out, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        step(1, 1, 2'd0, 0, 3'd0, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd0, 1, 32'hDEADBEEF);
        chk("bypass_x5", rs1_data_out, 32'hDEADBEEF);
        bubble(5'd5);
        chk("after_edge_x5", rs1_data_out, 32'hDEADBEEF);
        step(1, 1, 2'd0, 0, 3'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0, 5'd0, 1, 32'hDEADBEEF);
        bubble(5'd0);

        step(1, 1, 2'd1, 0, 3'b000, 5'd10, 32'h3, LD_WORD, 0, 5'd10, 0, 1, 32'hFFFFFF80);
        step(1, 1, 2'd1, 0, 3'b100, 5'd11, 32'h1, LD_WORD, 0, 5'd11, 0, 1, 32'h0000007F);
        step(1, 1, 2'd1, 0, 3'b001, 5'd12, 32'h2, LD_WORD, 0, 5'd12, 0, 1, 32'hFFFF80FF);
        step(1, 1, 2'd0, 1, 3'b101, 5'd13, 32'h0, LD_WORD, 0, 5'd13, 0, 1, 32'h00007F01);
        step(1, 1, 2'd1, 0, 3'b010, 5'd14, 32'h0, LD_WORD, 0, 5'd14, 5'd10, 1, 32'h80FF7F01);

        step(1, 1, 2'd0, 0, 3'd0, 5'd7, 32'h1234, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2'd1, 0, 3'b010, 5'd7, 32'h2, LD_WORD, 0, 5'd7, 0, 0, 0);
        rs1_addr_in = 5'd7;
        #1;
        chk("x7_kept", rs1_data_out, 32'h1234);
        chk("mis_pulse", misalign_out, 1'b1);
        bubble(5'd7);
        bubble(5'd7);

        step(1, 1, 2'd2, 0, 3'd0, 5'd1, 0, 0, 32'hFFFFFFFC, 5'd1, 0, 1, 32'h0);
        step(1, 1, 2'd2, 0, 3'd0, 5'd1, 0, 0, 32'h100, 5'd1, 0, 1, 32'h104);
        bubble(5'd1);

        #2 reset = 1'b1;
        #1;
        rs1_addr_in = 5'd5; rs2_addr_in = 5'd14;
        #1;
        chk("midrst_x5", rs1_data_out, 32'h0);
        chk("midrst_x14", rs2_data_out, 32'h0);
        chk("midrst_instret", instret_out, 64'h0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (i % 4 == 3) bubble(5'd2);
            else step(1, 1, 2'd0, 0, 3'd0, 5'd2, 32'(i), 0, 0, 5'd2, 0, 0, 0);
        end
        chk("count_10", instret_out, 64'd10);

        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        #1 release dut.r_instret;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        step(1, 0, 2'd0, 0, 3'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 2'd0, 0, 3'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_zero", instret_out, 64'h0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ($urandom % 5) != 0, 2'($urandom), ($urandom % 8) == 0,
                 3'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                 5'($urandom), 5'($urandom), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
